gpr_cdb_arbiter: RTL and testbench
==================================

GPR_CDB_ARBITER -- requirements
Module: gpr_cdb_arbiter

Interface
REQ-001 The block SHALL have parameter N_UNIT, default 4, meaning number of execution units requesting the GPR CDB (legal range 2..8).
REQ-002 The block SHALL use ROB_WIDTH from common.vh, meaning ROB tag width; it is not a module parameter.
REQ-003 clk  input  1  meaning single rising-edge clock for all state.
REQ-004 reset  input  1  meaning synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 req  req_if array [N_UNIT]  meaning per-unit handshake; .valid is a unit input, .ready is a grant output.
REQ-006 req_tag  input  N_UNIT x ROB_WIDTH  meaning ROB tag of the entry unit i dispatches this cycle, valid with req[i].valid.
REQ-007 req_result  input  N_UNIT x 32  meaning registered result of unit i, valid the cycle after its grant.
REQ-008 gpr_cdb  output  cdb_t (valid, ROB_WIDTH tag, 32 data)  meaning broadcast to ROB, GPR file and all reservation stations.

Function
REQ-009 The block SHALL assert at most one req[i].ready per cycle: one-hot grant, all-zero when no req[i].valid is high.
REQ-010 req[i].ready SHALL be combinational from req[*].valid and rr_ptr only, never from req[i].ready, with no combinational path from req_result.
REQ-011 Grant SHALL be round-robin: first i with req[i].valid=1, scanning rr_ptr, rr_ptr+1, ... modulo N_UNIT.
REQ-012 On a grant to unit g, rr_ptr SHALL update at the next edge to (g+1) mod N_UNIT, wrapping N_UNIT-1 -> 0; with no grant it SHALL hold.
REQ-013 A handshake SHALL complete in the cycle req[g].valid && req[g].ready; the unit removes that entry at the same edge.
REQ-014 At the grant edge the block SHALL register pend_valid=1, pend_id=g, pend_tag=req_tag[g]; with no grant, pend_valid=0.
REQ-015 Latency: in cycle t+1 after a grant in cycle t, gpr_cdb.valid SHALL be 1, gpr_cdb.tag=pend_tag and gpr_cdb.data=req_result[pend_id] (combinational mux).
REQ-016 When pend_valid=0, gpr_cdb SHALL drive valid=0, tag=0, data=0.
REQ-017 Back-to-back: a new grant in cycle t+1 SHALL coexist with the broadcast of the cycle-t grant; throughput is one broadcast per cycle, no bubbles.
REQ-018 The same unit SHALL be grantable in consecutive cycles when it is the only requester.
REQ-019 All N_UNIT requesting simultaneously SHALL each be granted exactly once within N_UNIT consecutive cycles, with no starvation.
REQ-020 A unit dropping valid without a grant SHALL NOT alter rr_ptr or pend state.

Reset
REQ-021 While reset=0 at an edge: rr_ptr=0, pend_valid=0, pend_id=0, pend_tag=0.
REQ-022 During reset, gpr_cdb SHALL read valid=0, tag=0, data=0 from the next cycle on, and all req[i].ready SHALL be 0 regardless of valids.
REQ-023 A grant coincident with an asserted reset SHALL be discarded, and no broadcast SHALL follow it.
REQ-024 The first cycle after reset release SHALL arbitrate from rr_ptr=0.

Verification
REQ-025 Single requester: valid[1]=1, tag=5 in cycle 0, result[1]=0x0000_0010 in cycle 1 -> ready=0010 in cycle 0; gpr_cdb={1,5,0x10} in cycle 1; rr_ptr=2.
REQ-026 All four valid for 4 cycles from reset -> grants 0,1,2,3 in order, one per cycle; gpr_cdb.valid=1 in cycles 1-4 with tags matching the grant order.
REQ-027 Wrap-around: rr_ptr=3, valid=1001 -> grant unit 3, then unit 0 next cycle, rr_ptr=1 afterwards.
REQ-028 Idle: all valid=0 for 3 cycles -> all ready=0, gpr_cdb.valid=0, data=0, rr_ptr unchanged.
REQ-029 Reset mid-stream: grant to unit 2 in cycle t with reset=0 at edge t -> gpr_cdb.valid=0 in t+1, rr_ptr=0, and unit 0 wins at release when valid=0101.
REQ-030 Random stress, 10k cycles, add_sub-style units as requesters -> at most one ready per cycle, every handshake produces exactly one broadcast one cycle later with the matching tag and result, and no unit waits more than N_UNIT cycles.

Source files
------------

// File: rtl/gpr_cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// Interfaces used by gpr_cdb_arbiter.
//
// req_if : one per execution unit requesting the GPR common data bus.
//   valid - unit has a finished entry to dispatch this cycle (unit -> arbiter)
//   ready - one-hot grant for this unit (arbiter -> unit)
//   master modport = execution unit side, slave modport = arbiter side.
//
// cdb_if : GPR common data bus broadcast to ROB, GPR file and reservation
//   stations.
//   valid - broadcast present this cycle
//   tag   - ROB tag of the broadcast entry
//   data  - 32-bit result
//   master modport = arbiter side, slave modport = consumers.
// ---------------------------------------------------------------------------
`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif

interface req_if;
  logic valid;
  logic ready;

  modport master (output valid, input  ready);
  modport slave  (input  valid, output ready);
endinterface

interface cdb_if;
  logic                   valid;
  logic [`ROB_WIDTH-1:0]  tag;
  logic [31:0]            data;

  modport master (output valid, output tag, output data);
  modport slave  (input  valid, input  tag, input  data);
endinterface

// File: rtl/gpr_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// gpr_cdb_arbiter
//
// Round-robin arbiter that grants one execution unit per cycle access to the
// GPR common data bus. The grant is issued combinationally in cycle t; the
// granted unit's ROB tag is captured at the edge and the unit's registered
// result is muxed onto the bus in cycle t+1, so one broadcast per cycle is
// sustained with no bubbles.
//
// Parameters:
//   N_UNIT     - number of requesting execution units (2..8)
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-low reset
//   req        - per-unit handshake (valid in, ready = one-hot grant out)
//   req_tag    - per-unit ROB tag, qualified by req[i].valid
//   req_result - per-unit registered result, valid the cycle after its grant
//   gpr_cdb    - broadcast {valid, tag, data}; all-zero when idle
// ---------------------------------------------------------------------------
`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif

module gpr_cdb_arbiter #(
  parameter int unsigned N_UNIT = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  req_if.slave                                  req [N_UNIT],
  input  logic [N_UNIT-1:0][`ROB_WIDTH-1:0]     req_tag,
  input  logic [N_UNIT-1:0][31:0]               req_result,
  cdb_if.master                                 gpr_cdb
);

  localparam int unsigned PTR_W = (N_UNIT > 1) ? $clog2(N_UNIT) : 1;
  localparam int unsigned TAG_W = `ROB_WIDTH;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [TAG_W-1:0] tag_t;

  localparam ptr_t LAST_ID = ptr_t'(N_UNIT - 1);

  // -------------------------------------------------------------------------
  // Interface array unpacking
  // -------------------------------------------------------------------------
  logic [N_UNIT-1:0] valid_vec;
  logic [N_UNIT-1:0] grant;

  for (genvar i = 0; i < N_UNIT; i++) begin : g_req
    assign valid_vec[i] = req[i].valid;
    assign req[i].ready = grant[i];
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  ptr_t rr_ptr;
  logic pend_valid;
  ptr_t pend_id;
  tag_t pend_tag;

  // -------------------------------------------------------------------------
  // Round-robin selection: first valid unit scanning rr_ptr, rr_ptr+1, ...
  // modulo N_UNIT. The scan index is wrapped by subtraction so N_UNIT need
  // not be a power of two. Grants are suppressed while reset is asserted so
  // nothing is captured into the pending slot at a reset edge.
  // -------------------------------------------------------------------------
  logic grant_any;
  ptr_t grant_id;

  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    if (reset) begin
      for (int unsigned k = 0; k < N_UNIT; k++) begin
        idx = {{(32-PTR_W){1'b0}}, rr_ptr} + k;
        if (idx >= N_UNIT) begin
          idx = idx - N_UNIT;
        end
        if (!grant_any && valid_vec[idx[PTR_W-1:0]]) begin
          grant_any = 1'b1;
          grant_id  = idx[PTR_W-1:0];
        end
      end
      if (grant_any) begin
        grant[grant_id] = 1'b1;
      end
    end
  end

  // Pointer advances just past the winner; wraps N_UNIT-1 -> 0.
  ptr_t rr_next;

  always_comb begin
    rr_next = rr_ptr;
    if (grant_any) begin
      rr_next = (grant_id == LAST_ID) ? '0 : ptr_t'(grant_id + 1'b1);
    end
  end

  // -------------------------------------------------------------------------
  // State register. A unit dropping valid without a grant produces no
  // grant_any, so rr_ptr holds and the pending slot simply empties.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr     <= '0;
      pend_valid <= 1'b0;
      pend_id    <= '0;
      pend_tag   <= '0;
    end else begin
      rr_ptr <= rr_next;
      if (grant_any) begin
        pend_valid <= 1'b1;
        pend_id    <= grant_id;
        pend_tag   <= req_tag[grant_id];
      end else begin
        pend_valid <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Broadcast. The result is taken live from the unit's output register in
  // the cycle after its grant, so data comes through a mux rather than being
  // captured here; the bus is forced to zero when nothing is pending.
  // -------------------------------------------------------------------------
  logic        cdb_valid;
  tag_t        cdb_tag;
  logic [31:0] cdb_data;

  always_comb begin
    cdb_valid = 1'b0;
    cdb_tag   = '0;
    cdb_data  = '0;
    if (pend_valid) begin
      cdb_valid = 1'b1;
      cdb_tag   = pend_tag;
      cdb_data  = req_result[pend_id];
    end
  end

  assign gpr_cdb.valid = cdb_valid;
  assign gpr_cdb.tag   = cdb_tag;
  assign gpr_cdb.data  = cdb_data;

  // -------------------------------------------------------------------------
  // Structural guarantees of the grant logic.
  // -------------------------------------------------------------------------
  a_grant_onehot: assert property (@(posedge clk) $onehot0(grant));
  a_grant_needs_valid: assert property (@(posedge clk) (grant & ~valid_vec) == '0);
  a_no_grant_in_reset: assert property (@(posedge clk) !reset |-> grant == '0);

endmodule

// File: tb/tb_gpr_cdb_arbiter.sv
`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif

module tb_gpr_cdb_arbiter;

  localparam int N  = 4;
  localparam int RW = `ROB_WIDTH;

  typedef logic [N-1:0][RW-1:0] tags_t;
  typedef struct {
    logic [RW-1:0] tag;
    logic [31:0]   data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]        valid_drv = '0;
  logic [N-1:0]        ready_mon;
  tags_t               tag_drv = '0;
  logic [N-1:0][31:0]  result_drv = '0;

  req_if req [N] ();
  cdb_if cdb ();

  for (genvar i = 0; i < N; i++) begin : g_units
    assign req[i].valid = valid_drv[i];
    assign ready_mon[i] = req[i].ready;
  end

  gpr_cdb_arbiter #(.N_UNIT(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_tag    (tag_drv),
    .req_result (result_drv),
    .gpr_cdb    (cdb)
  );

  // Scoreboard and counters
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int          m_rr     = 0;
  int          last_g   = -1;
  logic [31:0] last_res = '0;
  int          wait_cnt [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requester starting at the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic tags_t mk_tags(input int base);
    tags_t t;
    for (int i = 0; i < N; i++) t[i] = RW'(base + i);
    return t;
  endfunction

  // One clock cycle of stimulus: drive at the falling edge, check the grant
  // shortly after, update the model and push the expected broadcast.
  task automatic step(input logic rst_n, input logic [N-1:0] v, input tags_t t,
                      input logic [31:0] res, output int g);
    logic [N-1:0] exp_ready;
    int max_wait;
    @(negedge clk);
    reset     = rst_n;
    valid_drv = v;
    tag_drv   = t;
    for (int i = 0; i < N; i++) result_drv[i] = $urandom;
    if (last_g >= 0) result_drv[last_g] = last_res;
    #2;
    g = rst_n ? model_pick(v) : -1;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("grant", ready_mon, exp_ready);
    max_wait = 0;
    for (int i = 0; i < N; i++) begin
      if (rst_n && v[i] && i != g) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
    if (rst_n && v != '0) check("starvation_bound", (max_wait <= N) ? 1 : 0, 1);
    if (!rst_n) m_rr = 0;
    else if (g >= 0) m_rr = (g + 1) % N;
    if (g >= 0) begin
      sb.push_back('{tag: t[g], data: res});
      last_g   = g;
      last_res = res;
    end else begin
      last_g = -1;
    end
  endtask

  // Monitor: compares whatever the bus shows against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (cdb.valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL bcast_spurious: got tag %0h data %0h expected no broadcast at %0t",
                 cdb.tag, cdb.data, $time);
      end else begin
        e = sb.pop_front();
        check("bcast_tag", cdb.tag, e.tag);
        check("bcast_data", cdb.data, e.data);
      end
    end else begin
      check("idle_valid", cdb.valid, 1'b0);
      check("idle_tag", cdb.tag, '0);
      check("idle_data", cdb.data, '0);
      check("bcast_missing", sb.size(), 0);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  end

  logic          has [N];
  logic [RW-1:0] utag [N];

  initial begin
    int g;
    logic [N-1:0] v;
    tags_t t;
    for (int i = 0; i < N; i++) begin
      wait_cnt[i] = 0;
      has[i] = 1'b0;
      utag[i] = '0;
    end

    // Reset with requests present: no grant
    step(1'b0, '0, '0, 0, g);
    step(1'b0, '1, mk_tags(1), 32'hdead, g);

    // Single requester unit 1, tag 5, result 0x10
    step(1'b1, 4'b0010, mk_tags(4), 32'h0000_0010, g);
    step(1'b1, '0, '0, 0, g);

    // All four valid from reset: grants 0,1,2,3
    step(1'b0, '0, '0, 0, g);
    for (int c = 0; c < 4; c++) step(1'b1, '1, mk_tags(8), $urandom, g);

    // Wrap-around: get pointer to 3, then 1001 -> 3, 0, 3
    step(1'b1, 4'b0100, mk_tags(16), $urandom, g);
    for (int c = 0; c < 3; c++) step(1'b1, 4'b1001, mk_tags(20 + c), $urandom, g);

    // Idle
    for (int c = 0; c < 3; c++) step(1'b1, '0, mk_tags(30), 0, g);

    // Only requester granted back to back
    for (int c = 0; c < 3; c++) step(1'b1, 4'b0100, mk_tags(40 + c), $urandom, g);

    // Reset mid-stream then release with 0101
    step(1'b1, 4'b0100, mk_tags(48), $urandom, g);
    step(1'b0, 4'b0100, mk_tags(52), $urandom, g);
    step(1'b1, 4'b0101, mk_tags(56), $urandom, g);

    // Random stress with units holding entries until served
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!has[i] && $urandom_range(0, 9) < 6) begin
          has[i]  = 1'b1;
          utag[i] = RW'($urandom);
        end else if (has[i] && $urandom_range(0, 19) == 0) begin
          has[i] = 1'b0;
        end
        v[i] = has[i];
        t[i] = utag[i];
      end
      step(($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1, v, t, $urandom, g);
      if (g >= 0) has[g] = 1'b0;
    end

    step(1'b1, '0, '0, 0, g);
    step(1'b1, '0, '0, 0, g);
    @(negedge clk);
    #3;
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
